// File: rtl/tlb_walk_ctrl.sv
// tlb_walk_ctrl: two-level hardware page-table walker and TLB control sequencer.
// On a miss it reads the L1 directory entry and the L2 PTE through a single
// outstanding memory read port, then writes the translation into the TLB with
// one update strobe. Software invalidates share the same TLB control port and
// are serialised through the same FSM.
//
// Handshake semantics (all valid/ready pairs): a transfer happens on the rising
// clock edge where both valid and ready are high. A source holds valid and its
// payload stable until that edge; a sink may raise ready without waiting for
// valid. miss_ready is withheld while inval_valid is high in IDLE, so an
// invalidate that collides with a miss is taken first and the miss stays pending.
module tlb_walk_ctrl #(
  parameter int PAGE_INDEX_BITS = 20,
  parameter int ASID_WIDTH      = 8,
  parameter int PADDR_WIDTH     = 32,
  parameter int L2_IDX_BITS     = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  // page-table base and flush
  input  logic [PAGE_INDEX_BITS-1:0] ptbr,
  input  logic                       flush,
  // miss request / response
  input  logic                       miss_valid,
  output logic                       miss_ready,
  input  logic [PAGE_INDEX_BITS-1:0] miss_vpage,
  input  logic [ASID_WIDTH-1:0]      miss_asid,
  output logic                       resp_valid,
  output logic                       resp_fault,
  // invalidate request
  input  logic                       inval_valid,
  output logic                       inval_ready,
  input  logic                       inval_all,
  input  logic [PAGE_INDEX_BITS-1:0] inval_vpage,
  input  logic [ASID_WIDTH-1:0]      inval_asid,
  // memory read port
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [PADDR_WIDTH-1:0]     mem_addr,
  input  logic                       mem_resp_valid,
  input  logic [31:0]                mem_resp_data,
  // TLB control
  output logic                       tlb_update_en,
  output logic                       tlb_invalidate_en,
  output logic                       tlb_invalidate_all_en,
  output logic [PAGE_INDEX_BITS-1:0] tlb_vpage_idx,
  output logic [ASID_WIDTH-1:0]      tlb_asid,
  output logic [PAGE_INDEX_BITS-1:0] tlb_ppage_idx,
  output logic                       tlb_present,
  output logic                       tlb_exe_writable,
  output logic                       tlb_supervisor,
  output logic                       tlb_global,
  output logic                       tlb_busy,
  // FSM state for observation
  output logic [3:0]                 dbg_state
);

  // Address arithmetic is done at the wider of the natural width and the
  // port width, then truncated to PADDR_WIDTH.
  localparam int FULL_W = PAGE_INDEX_BITS + 12;
  localparam int AW     = (FULL_W > PADDR_WIDTH) ? FULL_W : PADDR_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_L1_REQ  = 4'd1,
    S_L1_WAIT = 4'd2,
    S_L2_REQ  = 4'd3,
    S_L2_WAIT = 4'd4,
    S_FILL    = 4'd5,
    S_SETTLE  = 4'd6,
    S_INVAL   = 4'd7,
    S_DRAIN   = 4'd8
  } state_t;

  state_t state_q, state_d;

  // latched request fields; shared by walks and invalidates
  logic [PAGE_INDEX_BITS-1:0] vpage_q;
  logic [ASID_WIDTH-1:0]      asid_q;
  logic [19:0]                dir_q;
  logic [PAGE_INDEX_BITS-1:0] ppage_q;
  logic                       present_q, exe_wr_q, super_q, global_q;

  // registered strobes
  logic upd_q, inv_q, inv_all_q, resp_q;

  // FSM decode helpers
  logic miss_accept, inval_accept, dir_load, pte_load, fault_now;

  logic [AW-1:0] l1_addr, l2_addr, addr_full;
  logic          unused_bits;

  // L1 / L2 PTE byte addresses from the latched vpage
  always_comb begin
    l1_addr = AW'({ptbr, 12'b0}) + (AW'(vpage_q[PAGE_INDEX_BITS-1:L2_IDX_BITS]) << 2);
    l2_addr = AW'({dir_q, 12'b0}) + (AW'(vpage_q[L2_IDX_BITS-1:0]) << 2);
  end

  // drive the request address only while a request is presented
  always_comb begin
    addr_full = '0;
    if (state_q == S_L1_REQ)      addr_full = l1_addr;
    else if (state_q == S_L2_REQ) addr_full = l2_addr;
  end

  assign mem_addr    = addr_full[PADDR_WIDTH-1:0];
  assign unused_bits = ^{mem_resp_data[11:4], addr_full};

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next-state logic and load enables
  always_comb begin
    state_d      = state_q;
    miss_accept  = 1'b0;
    inval_accept = 1'b0;
    dir_load     = 1'b0;
    pte_load     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (inval_valid) begin
          inval_accept = 1'b1;
          state_d      = S_INVAL;
        end else if (miss_valid) begin
          miss_accept = 1'b1;
          state_d     = S_L1_REQ;
        end
      end
      S_L1_REQ: begin
        // flush suppresses mem_req_valid, so nothing can be in flight
        if (flush)              state_d = S_IDLE;
        else if (mem_req_ready) state_d = S_L1_WAIT;
      end
      S_L1_WAIT: begin
        if (mem_resp_valid) begin
          // a response coinciding with flush is simply discarded
          if (flush || !mem_resp_data[0]) begin
            state_d = S_IDLE;
          end else begin
            dir_load = 1'b1;
            state_d  = S_L2_REQ;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_L2_REQ: begin
        if (flush)              state_d = S_IDLE;
        else if (mem_req_ready) state_d = S_L2_WAIT;
      end
      S_L2_WAIT: begin
        if (mem_resp_valid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            pte_load = 1'b1;
            state_d  = S_FILL;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_FILL:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_IDLE;
      S_INVAL:  state_d = S_SETTLE;
      S_DRAIN: begin
        if (mem_resp_valid) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // request and translation field capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vpage_q   <= '0;
      asid_q    <= '0;
      dir_q     <= '0;
      ppage_q   <= '0;
      present_q <= 1'b0;
      exe_wr_q  <= 1'b0;
      super_q   <= 1'b0;
      global_q  <= 1'b0;
    end else begin
      if (miss_accept) begin
        vpage_q <= miss_vpage;
        asid_q  <= miss_asid;
      end else if (inval_accept) begin
        vpage_q <= inval_vpage;
        asid_q  <= inval_asid;
      end
      if (dir_load) dir_q <= mem_resp_data[31:12];
      if (pte_load) begin
        ppage_q   <= PAGE_INDEX_BITS'(mem_resp_data[31:12]);
        present_q <= mem_resp_data[0];
        exe_wr_q  <= mem_resp_data[1];
        super_q   <= mem_resp_data[2];
        global_q  <= mem_resp_data[3];
      end
    end
  end

  // one-cycle strobes, registered on entry to FILL / INVAL / SETTLE-after-FILL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_q     <= 1'b0;
      inv_q     <= 1'b0;
      inv_all_q <= 1'b0;
      resp_q    <= 1'b0;
    end else begin
      upd_q     <= pte_load;
      inv_q     <= inval_accept && !inval_all;
      inv_all_q <= inval_accept && inval_all;
      resp_q    <= (state_q == S_FILL);
    end
  end

  // a faulting L1 entry is reported in the same cycle its data arrives
  assign fault_now = (state_q == S_L1_WAIT) && mem_resp_valid && !mem_resp_data[0] && !flush;

  assign miss_ready    = (state_q == S_IDLE) && !inval_valid;
  assign inval_ready   = (state_q == S_IDLE);
  assign mem_req_valid = ((state_q == S_L1_REQ) || (state_q == S_L2_REQ)) && !flush;

  assign resp_valid = resp_q | fault_now;
  assign resp_fault = fault_now;

  assign tlb_update_en         = upd_q;
  assign tlb_invalidate_en     = inv_q;
  assign tlb_invalidate_all_en = inv_all_q;
  assign tlb_vpage_idx         = vpage_q;
  assign tlb_asid              = asid_q;
  assign tlb_ppage_idx         = ppage_q;
  assign tlb_present           = present_q;
  assign tlb_exe_writable      = exe_wr_q;
  assign tlb_supervisor        = super_q;
  assign tlb_global            = global_q;
  assign tlb_busy              = (state_q != S_IDLE);
  assign dbg_state             = state_q;

endmodule
